// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage in front of a 1-cycle-latency SRAM.
// Issues one read per granted cycle, captures the registered read data the
// following cycle into a small FIFO, and hands (pc, instr) to decode.
//
// Handshake: o_valid/i_ready. The head entry moves to decode on any cycle
// where o_valid & i_ready at posedge clk. While o_valid=1 and i_ready=0 the
// head (o_instr, o_pc) is held unchanged. The SRAM side uses o_mem_req/i_mem_gnt.
// A request is consumed only when both are high at the edge.
//
// Optional build macro: FETCH_PERF_EN adds o_fetch_cnt and o_flush_cnt.
module instr_fetch #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_halt,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_mem_req,
  input  logic                  i_mem_gnt,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  input  logic [WORD_WIDTH-1:0] i_mem_data,
  output logic                  o_valid,
  output logic [WORD_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  input  logic                  i_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]           o_fetch_cnt,
  output logic [15:0]           o_flush_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC_V = ADDR_WIDTH'(RESET_PC);
  localparam logic [CNT_W:0]        DEPTH_V    = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]   issue_pc_q, issue_pc_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [WORD_WIDTH-1:0]   instr_mem_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0]   instr_mem_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem_q    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem_d    [FIFO_DEPTH];

  logic [CNT_W:0]          occupancy;
  logic                    grant;
  logic                    push;
  logic                    pop;

  // Control FSM: IDLE until started, then RUN/HALT following the halt level.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_RUN;
      ST_RUN:  if (i_halt)  state_d = ST_HALT;
      ST_HALT: if (!i_halt) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue, capture and handshake decode. A redirect cancels this cycle's
  // grant and drops the word landing from the previous grant.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    o_mem_req  = (state_q == ST_RUN) && (occupancy < DEPTH_V);
    o_mem_addr = pc_q;
    o_mem_we   = 1'b0;
    o_valid    = (count_q != '0);
    o_instr    = o_valid ? instr_mem_q[rd_ptr_q] : '0;
    o_pc       = o_valid ? pc_mem_q[rd_ptr_q]    : '0;
    grant      = o_mem_req && i_mem_gnt && !i_redirect;
    push       = inflight_q && !i_redirect;
    pop        = o_valid && i_ready;
  end

  // Next-state for PC, in-flight tracking and FIFO storage.
  always_comb begin
    pc_d        = pc_q;
    inflight_d  = 1'b0;
    issue_pc_d  = issue_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (i_redirect) begin
      pc_d     = i_redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (grant) begin
        pc_d       = pc_q + ADDR_WIDTH'(1);
        inflight_d = 1'b1;
        issue_pc_d = pc_q;
      end
      if (push) begin
        instr_mem_d[wr_ptr_q] = i_mem_data;
        pc_mem_d[wr_ptr_q]    = issue_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC_V;
      inflight_q <= 1'b0;
      issue_pc_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      issue_pc_q  <= issue_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        flush_hit;

  // Perf counters: pushes, and redirects that actually threw work away
  // (a word popped in the redirect cycle was accepted, not discarded).
  always_comb begin
    flush_hit   = i_redirect && (inflight_q || (count_q > CNT_W'(pop)));
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (push)      fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (flush_hit) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed + randomized bench for instr_fetch with a
// registered-read SRAM model and a transaction-level reference model.
module tb_instr_fetch;
  localparam int AW    = 12;
  localparam int WW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_halt = 1'b0;
  logic          i_redirect = 1'b0;
  logic [AW-1:0] i_redirect_pc = '0;
  logic          o_mem_req;
  logic          i_mem_gnt = 1'b0;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_we;
  logic [WW-1:0] i_mem_data = '0;
  logic          o_valid;
  logic [WW-1:0] o_instr;
  logic [AW-1:0] o_pc;
  logic          i_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [15:0]   o_fetch_cnt;
  logic [15:0]   o_flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [WW-1:0] sram [4096];

  // clock/reset block
  always #5 clk = ~clk;

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_halt        (i_halt),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_mem_req     (o_mem_req),
    .i_mem_gnt     (i_mem_gnt),
    .o_mem_addr    (o_mem_addr),
    .o_mem_we      (o_mem_we),
    .i_mem_data    (i_mem_data),
    .o_valid       (o_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_ready       (i_ready)
`ifdef FETCH_PERF_EN
    ,
    .o_fetch_cnt   (o_fetch_cnt),
    .o_flush_cnt   (o_flush_cnt)
`endif
  );

  // SRAM: registered read on granted cycles; otherwise the port carries
  // some other master's data, modelled as noise.
  always @(posedge clk) begin
    if (o_mem_req && i_mem_gnt) i_mem_data <= sram[o_mem_addr];
    else                        i_mem_data <= WW'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: mode (0 idle, 1 run, 2 halt), words buffered for decode,
  // word in flight, next PC to issue, next PC decode must see.
  int            mode_m = 0;
  int            buffered_m = 0;
  int            inflight_m = 0;
  logic [AW-1:0] issue_pc_m = '0;
  logic [AW-1:0] next_pc_m = '0;
  bit            req_e;
  bit            pop_e;
  bit            gnt_e;

  // scoreboard: checked at negedge, then model advanced across the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      mode_m     = 0;
      buffered_m = 0;
      inflight_m = 0;
      issue_pc_m = AW'(0);
      next_pc_m  = AW'(0);
    end else begin
      req_e = (mode_m == 1) && (buffered_m + inflight_m < DEPTH);
      check("mem_we", 32'(o_mem_we), 32'(0));
      check("mem_req", 32'(o_mem_req), 32'(req_e));
      if (req_e) check("mem_addr", 32'(o_mem_addr), 32'(issue_pc_m));
      check("valid", 32'(o_valid), 32'(buffered_m > 0));
      if (buffered_m > 0) begin
        check("head_pc", 32'(o_pc), 32'(next_pc_m));
        check("head_instr", 32'(o_instr), 32'(sram[next_pc_m]));
      end
      pop_e = (buffered_m > 0) && i_ready;
      gnt_e = req_e && i_mem_gnt;
      if (pop_e) next_pc_m = next_pc_m + AW'(1);
      if (i_redirect) begin
        buffered_m = 0;
        inflight_m = 0;
        issue_pc_m = i_redirect_pc;
        next_pc_m  = i_redirect_pc;
      end else begin
        buffered_m = buffered_m + inflight_m - int'(pop_e);
        inflight_m = int'(gnt_e);
        if (gnt_e) issue_pc_m = issue_pc_m + AW'(1);
      end
      case (mode_m)
        0: if (i_start) mode_m = 1;
        1: if (i_halt)  mode_m = 2;
        2: if (!i_halt) mode_m = 1;
        default: mode_m = 0;
      endcase
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic [AW-1:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    step();
    i_redirect    = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (!o_valid && n < max_cycles) begin
      step();
      n++;
    end
    if (!o_valid) check(tag, 32'(o_valid), 32'(1));
  endtask

  int            grants;
  logic [AW-1:0] seen_pc [4];
  int            nseen;

  initial begin
    for (int a = 0; a < 4096; a++) sram[a] = WW'($urandom);
    for (int a = 0; a < 4; a++) sram[a] = 16'hA000 + WW'(a);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'(0));
    check("rst_req", 32'(o_mem_req), 32'(0));
    check("rst_instr", 32'(o_instr), 32'(0));
    check("rst_pc", 32'(o_pc), 32'(0));
    check("rst_we", 32'(o_mem_we), 32'(0));
    rst_n = 1'b1;
    step();

    // first fetch latency and back-to-back stream
    i_start = 1'b1; i_mem_gnt = 1'b1; i_ready = 1'b1;
    step();
    i_start = 1'b0;
    check("lat_req", 32'(o_mem_req), 32'(1));
    check("lat_addr", 32'(o_mem_addr), 32'(0));
    step();
    check("lat_n1_valid", 32'(o_valid), 32'(0));
    step();
    for (int k = 0; k < 4; k++) begin
      check("first_valid", 32'(o_valid), 32'(1));
      check("first_pc", 32'(o_pc), 32'(k));
      check("first_instr", 32'(o_instr), 32'(16'hA000 + k));
      step();
    end

    // decode stalled: exactly FIFO_DEPTH grants, then requests stop
    i_ready = 1'b0;
    pulse_redirect(12'h010);
    grants = 0;
    repeat (8) begin
      if (o_mem_req && i_mem_gnt) grants++;
      step();
    end
    check("stall_grants", 32'(grants), 32'(DEPTH));
    check("stall_req", 32'(o_mem_req), 32'(0));
    check("stall_instr", 32'(o_instr), 32'(sram[12'h010]));
    i_ready = 1'b1;
    repeat (10) step();

    // alternating grant, random ready
    for (int i = 0; i < 40; i++) begin
      i_mem_gnt = (i % 2) == 0;
      i_ready   = $urandom_range(0, 3) != 0;
      step();
    end

    // redirect with two buffered words and one in flight
    i_ready = 1'b0; i_mem_gnt = 1'b1;
    pulse_redirect(12'h700);
    repeat (3) step();
    check("pre_flush_valid", 32'(o_valid), 32'(1));
    pulse_redirect(12'h800);
    check("post_flush_valid", 32'(o_valid), 32'(0));
    i_ready = 1'b1;
    wait_valid(10, "flush_timeout");
    check("flush_pc", 32'(o_pc), 32'(12'h800));
    check("flush_instr", 32'(o_instr), 32'(sram[12'h800]));

    // PC wrap
    pulse_redirect(12'hFFE);
    nseen = 0;
    for (int i = 0; i < 20 && nseen < 4; i++) begin
      if (o_valid && i_ready) begin
        seen_pc[nseen] = o_pc;
        nseen++;
      end
      step();
    end
    check("wrap_count", 32'(nseen), 32'(4));
    check("wrap_pc0", 32'(seen_pc[0]), 32'(12'hFFE));
    check("wrap_pc1", 32'(seen_pc[1]), 32'(12'hFFF));
    check("wrap_pc2", 32'(seen_pc[2]), 32'(12'h000));
    check("wrap_pc3", 32'(seen_pc[3]), 32'(12'h001));

    // randomized traffic: grants, backpressure, halts, redirects, stray starts
    for (int i = 0; i < 600; i++) begin
      i_mem_gnt     = $urandom_range(0, 3) != 0;
      i_ready       = $urandom_range(0, 3) != 0;
      i_redirect    = $urandom_range(0, 24) == 0;
      i_redirect_pc = AW'($urandom);
      i_start       = $urandom_range(0, 49) == 0;
      if ($urandom_range(0, 29) == 0) i_halt = ~i_halt;
      step();
    end
    i_halt = 1'b0; i_redirect = 1'b0; i_start = 1'b0;

    // asynchronous reset with a non-empty FIFO
    i_ready = 1'b0; i_mem_gnt = 1'b1;
    repeat (4) step();
    check("prerst_valid", 32'(o_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_valid), 32'(0));
    check("async_rst_req", 32'(o_mem_req), 32'(0));
`ifdef FETCH_PERF_EN
    check("rst_fetch_cnt", 32'(o_fetch_cnt), 32'(0));
    check("rst_flush_cnt", 32'(o_flush_cnt), 32'(0));
`endif
    step();
    step();
    rst_n = 1'b1; i_ready = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_valid(10, "restart_timeout");
    check("restart_pc", 32'(o_pc), 32'(0));
    check("restart_instr", 32'(o_instr), 32'(16'hA000));
    repeat (6) step();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
